alu_mdu_pipe: RTL and testbench

//  Parametrised execute-stage ALU with an integrated iterative multiply/divide unit (RV32M ops).

---
 rtl/alu_mdu_pipe_pkg.sv | 55 +++++
 rtl/alu_mdu_pipe_mdu_iter.sv | 103 ++++++++++
 rtl/alu_mdu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_mdu_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pipe_pkg.sv
// Op codes, FSM states and decode helpers shared by the execute-stage ALU and its mul/div engine.
package alu_mdu_pipe_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_SLT,
      OP_SLTU,
      OP_BEQ    = 5'd10,
      OP_BNE,
      OP_BLT,
      OP_BGE,
      OP_BLTU,
      OP_BGEU,
      OP_MUL    = 5'd16,
      OP_MULH,
      OP_MULHSU,
      OP_MULHU,
      OP_DIV,
      OP_DIVU,
      OP_REM,
      OP_REMU,
      OP_NONE   = 5'd31
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op >= OP_MUL) && (op <= OP_REMU);
   endfunction

   function automatic logic is_branch(input logic [4:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return (op >= OP_DIV) && (op <= OP_REMU);
   endfunction

   function automatic logic is_sdiv(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/alu_mdu_pipe_mdu_iter.sv
// Iterative one-bit-per-cycle multiply (shift-add) / divide (restoring) engine working on
// operand magnitudes; the sign correction is applied to the registered result in the fix cycle.
module mdu_iter
   import alu_mdu_pipe_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_kill,
   input  logic [4:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_last,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0]   r_hi, r_lo, r_b;
   logic [CW-1:0]     r_cnt;
   logic              r_busy, r_fix, r_div, r_neg_q, r_neg_r, r_sel_hi;

   logic              w_sgn_a, w_sgn_b, w_div, w_sel_hi;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_quo, w_rem;
   logic [2*XLEN-1:0] w_prod, w_prod_fix, w_first;

   // Mul: {hi,lo} starts as {0,multiplier} and shifts right. Div: hi is the partial
   // remainder, lo shifts the dividend out at the top and the quotient in at the bottom.
   function automatic logic [2*XLEN-1:0] f_step(input logic div, input logic [XLEN-1:0] hi,
                                                input logic [XLEN-1:0] lo, input logic [XLEN-1:0] b);
      logic [XLEN:0] sum, shl, diff;
      if (div) begin
         shl  = {hi, lo[XLEN-1]};
         diff = shl - {1'b0, b};
         if (diff[XLEN]) f_step = {shl[XLEN-1:0], lo[XLEN-2:0], 1'b0};
         else            f_step = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      end else begin
         sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
         f_step = {sum, lo[XLEN-1:1]};
      end
   endfunction

   assign w_div    = is_div(i_op);
   assign w_sgn_a  = i_a[XLEN-1] & ((i_op == OP_MUL) | (i_op == OP_MULH) | (i_op == OP_MULHSU) | is_sdiv(i_op));
   assign w_sgn_b  = i_b[XLEN-1] & ((i_op == OP_MUL) | (i_op == OP_MULH) | is_sdiv(i_op));
   assign w_sel_hi = (i_op == OP_MULH) | (i_op == OP_MULHSU) | (i_op == OP_MULHU) |
                     (i_op == OP_REM) | (i_op == OP_REMU);
   assign w_mag_a  = w_sgn_a ? -i_a : i_a;
   assign w_mag_b  = w_sgn_b ? -i_b : i_b;
   assign w_first  = f_step(w_div, '0, w_mag_a, w_mag_b);

   // The first iteration happens on the start edge, leaving XLEN-1 more in the busy phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_fix    <= 1'b0;
         r_div    <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_sel_hi <= 1'b0;
      end else if (i_kill) begin
         r_busy <= 1'b0;
         r_fix  <= 1'b0;
      end else if (i_start) begin
         {r_hi, r_lo} <= w_first;
         r_b      <= w_mag_b;
         r_cnt    <= CW'(1);
         r_busy   <= 1'b1;
         r_fix    <= 1'b0;
         r_div    <= w_div;
         r_neg_q  <= w_sgn_a ^ w_sgn_b;
         r_neg_r  <= w_sgn_a;
         r_sel_hi <= w_sel_hi;
      end else if (r_busy) begin
         {r_hi, r_lo} <= f_step(r_div, r_hi, r_lo, r_b);
         r_cnt        <= r_cnt + CW'(1);
         if (r_cnt == CW'(XLEN-1)) begin
            r_busy <= 1'b0;
            r_fix  <= 1'b1;
         end
      end else begin
         r_fix <= 1'b0;
      end
   end

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo      = r_neg_q ? -r_lo : r_lo;
   assign w_rem      = r_neg_r ? -r_hi : r_hi;

   assign o_last   = r_busy & (r_cnt == CW'(XLEN-1));
   assign o_done   = r_fix;
   assign o_result = r_div ? (r_sel_hi ? w_rem : w_quo)
                           : (r_sel_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0]);

endmodule

// File: rtl/alu_mdu_pipe.sv
// Execute-stage ALU with an iterative RV32M mul/div unit, valid/ready on both sides.
// Single-cycle ops and divide corner cases answer one cycle after accept.
module alu_mdu_pipe
   import alu_mdu_pipe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OP_W = 5
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] rD1,
   input  logic [XLEN-1:0] rD2,
   input  logic [XLEN-1:0] imm,
   input  logic            alub_sel,
   input  logic [OP_W-1:0] alu_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] C,
   output logic            bf
);

   localparam int              SH_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

   state_e                 r_state;
   logic                   r_out_valid, r_bf;
   logic [XLEN-1:0]        r_c;

   logic [4:0]             w_op;
   logic [XLEN-1:0]        w_b, w_alu_c, w_mdu_res;
   logic signed [XLEN-1:0] w_a_s, w_b_s;
   logic [SH_W-1:0]        w_sh;
   logic                   w_alu_bf, w_lt_s, w_lt_u, w_eq;
   logic                   w_div_zero, w_div_ovf, w_fast, w_accept, w_start;
   logic                   w_mdu_last, w_mdu_done;

   // Codes wider than the defined 5-bit space decode as undefined.
   assign w_op       = ((alu_op >> 5) == '0) ? alu_op[4:0] : OP_NONE;
   assign w_b        = alub_sel ? imm : rD2;
   assign w_a_s      = rD1;
   assign w_b_s      = w_b;
   assign w_sh       = w_b[SH_W-1:0];
   assign w_lt_s     = w_a_s < w_b_s;
   assign w_lt_u     = rD1 < w_b;
   assign w_eq       = rD1 == w_b;
   assign w_div_zero = w_b == '0;
   assign w_div_ovf  = is_sdiv(w_op) & (rD1 == MIN) & (w_b == '1);
   assign w_fast     = is_div(w_op) & (w_div_zero | w_div_ovf);

   assign in_ready   = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
   assign w_accept   = in_valid & in_ready & ~flush;
   assign w_start    = w_accept & is_muldiv(w_op) & ~w_fast;

   assign out_valid  = r_out_valid;
   assign C          = r_c;
   assign bf         = r_bf;

   always_comb begin
      w_alu_c  = '0;
      w_alu_bf = 1'b0;
      case (w_op)
         OP_ADD:  w_alu_c = rD1 + w_b;
         OP_SUB:  w_alu_c = rD1 + ~w_b + ONE;
         OP_AND:  w_alu_c = rD1 & w_b;
         OP_OR:   w_alu_c = rD1 | w_b;
         OP_XOR:  w_alu_c = rD1 ^ w_b;
         OP_SLL:  w_alu_c = rD1 << w_sh;
         OP_SRL:  w_alu_c = rD1 >> w_sh;
         OP_SRA:  w_alu_c = w_a_s >>> w_sh;
         OP_SLT:  w_alu_c = {{(XLEN-1){1'b0}}, w_lt_s};
         OP_SLTU: w_alu_c = {{(XLEN-1){1'b0}}, w_lt_u};
         OP_BEQ:  w_alu_bf = w_eq;
         OP_BNE:  w_alu_bf = ~w_eq;
         OP_BLT:  w_alu_bf = w_lt_s;
         OP_BGE:  w_alu_bf = ~w_lt_s;
         OP_BLTU: w_alu_bf = w_lt_u;
         OP_BGEU: w_alu_bf = ~w_lt_u;
         // Only reached on the fast path: divide by zero or signed MIN / -1.
         OP_DIV, OP_DIVU: w_alu_c = w_div_zero ? '1 : MIN;
         OP_REM, OP_REMU: w_alu_c = w_div_zero ? rD1 : '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_c         <= '0;
         r_bf        <= 1'b0;
      end else if (flush) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_BUSY: begin
               if (w_mdu_last) r_state <= ST_FIX;
            end
            ST_FIX: begin
               if (w_mdu_done) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_c         <= w_mdu_res;
                  r_bf        <= 1'b0;
               end
            end
            default: begin
               if (w_accept) begin
                  if (w_start) begin
                     r_state     <= ST_BUSY;
                     r_out_valid <= 1'b0;
                  end else begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                     r_c         <= w_alu_c;
                     r_bf        <= w_alu_bf;
                  end
               end else if ((r_state == ST_DONE) && out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

   mdu_iter #(
      .XLEN(XLEN)
   ) u_mdu (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_start),
      .i_kill   (flush),
      .i_op     (w_op),
      .i_a      (rD1),
      .i_b      (w_b),
      .o_last   (w_mdu_last),
      .o_done   (w_mdu_done),
      .o_result (w_mdu_res)
   );

endmodule

// File: tb/tb_alu_mdu_pipe.sv
// Directed bench for alu_mdu_pipe: a 32-bit instance for the full op set and handshake,
// plus a 16-bit instance for width-dependent latency and flush.
module tb_alu_mdu_pipe;
   import alu_mdu_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, in_valid, out_ready, alub_sel;
   logic [4:0]  alu_op;
   logic [31:0] rD1, rD2, imm;
   logic        in_ready, out_valid, bf;
   logic [31:0] C;

   logic        flush16, iv16, or16, sel16;
   logic [4:0]  op16;
   logic [15:0] a16, b16, imm16;
   logic        ir16, ov16, bf16;
   logic [15:0] c16;

   int n_chk = 0;
   int n_err = 0;
   int lat;
   int seen;

   always #5 clk = ~clk;

   alu_mdu_pipe #(.XLEN(32), .OP_W(5)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .rD1(rD1), .rD2(rD2), .imm(imm), .alub_sel(alub_sel), .alu_op(alu_op),
      .out_valid(out_valid), .out_ready(out_ready), .C(C), .bf(bf)
   );

   alu_mdu_pipe #(.XLEN(16), .OP_W(5)) u_dut16 (
      .clk(clk), .rst(rst), .flush(flush16), .in_valid(iv16), .in_ready(ir16),
      .rD1(a16), .rD2(b16), .imm(imm16), .alub_sel(sel16), .alu_op(op16),
      .out_valid(ov16), .out_ready(or16), .C(c16), .bf(bf16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, scramble operands after accept, return cycles until out_valid.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sel, output int l);
      alu_op   = op;
      rD1      = a;
      alub_sel = sel;
      rD2      = sel ? 32'h0BAD_0BAD : b;
      imm      = sel ? b : 32'h0BAD_0BAD;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rD1      = 32'hDEAD_BEEF;
      rD2      = 32'h1234_5678;
      imm      = 32'h5555_AAAA;
      l = 1;
      while (!out_valid && l < 100) begin
         tick();
         l++;
      end
   endtask

   task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, output int l);
      op16 = op;
      a16  = a;
      b16  = b;
      iv16 = 1'b1;
      tick();
      iv16 = 1'b0;
      a16  = 16'hBEEF;
      b16  = 16'h0F0F;
      l = 1;
      while (!ov16 && l < 100) begin
         tick();
         l++;
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alub_sel = 1'b0;
      alu_op = OP_ADD; rD1 = '0; rD2 = '0; imm = '0;
      flush16 = 1'b0; iv16 = 1'b0; or16 = 1'b1; sel16 = 1'b0; op16 = OP_ADD;
      a16 = '0; b16 = '0; imm16 = '0;
      tick();
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_c", C, 0);
      check("rst_bf", bf, 0);
      check("rst16_in_ready", ir16, 1);
      check("rst16_out_valid", ov16, 0);
      rst = 1'b0;
      tick();

      // Single-cycle ALU and branches
      run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, lat);
      check("add_c", C, 32'h8000_0000);
      check("add_lat", lat, 1);
      check("add_bf", bf, 0);
      run_op(OP_SUB, 32'd5, 32'd7, 1'b0, lat);
      check("sub_c", C, 32'hFFFF_FFFE);
      run_op(5'd24, 32'd3, 32'd4, 1'b0, lat);
      check("undef_c", C, 0);
      check("undef_lat", lat, 1);
      run_op(OP_SRA, 32'h8000_0000, 32'h24, 1'b0, lat);
      check("sra_c", C, 32'hF800_0000);
      run_op(OP_SLL, 32'h1, 32'd31, 1'b1, lat);
      check("sll_c", C, 32'h8000_0000);
      run_op(OP_SRL, 32'h8000_0000, 32'd31, 1'b0, lat);
      check("srl_c", C, 32'h1);
      run_op(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
      check("xor_c", C, 32'h0FF0_0FF0);
      run_op(OP_SLT, 32'h8000_0000, 32'h1, 1'b0, lat);
      check("slt_c", C, 32'h1);
      run_op(OP_SLTU, 32'h8000_0000, 32'h1, 1'b0, lat);
      check("sltu_c", C, 32'h0);
      run_op(OP_BLT, 32'h8000_0000, 32'h1, 1'b0, lat);
      check("blt_bf", bf, 1);
      check("blt_c", C, 0);
      run_op(OP_BGEU, 32'h8000_0000, 32'h1, 1'b0, lat);
      check("bgeu_bf", bf, 1);
      run_op(OP_BGE, 32'h8000_0000, 32'h1, 1'b0, lat);
      check("bge_bf", bf, 0);
      run_op(OP_BNE, 32'd5, 32'd5, 1'b1, lat);
      check("bne_bf", bf, 0);
      run_op(OP_BEQ, 32'd5, 32'd5, 1'b1, lat);
      check("beq_bf", bf, 1);

      // Reset in the middle of a divide
      run_op(OP_ADD, 32'd1, 32'd2, 1'b0, lat);
      check("pre_rst_c", C, 32'd3);
      alu_op = OP_DIV; rD1 = 32'd100; rD2 = 32'd7; alub_sel = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("busy_in_ready", in_ready, 0);
      check("busy_out_valid", out_valid, 0);
      #1 rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_c", C, 0);
      rst = 1'b0;
      tick();

      // Multiply
      run_op(OP_MULH, 32'hFFFF_FFFE, 32'd3, 1'b0, lat);
      check("mulh_c", C, 32'hFFFF_FFFF);
      check("mulh_lat", lat, 33);
      run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
      check("mulhu_c", C, 32'hFFFF_FFFE);
      run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
      check("mul_c", C, 32'h0000_0001);
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
      check("mulhsu_c", C, 32'hFFFF_FFFF);

      // Divide, including fast paths
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
      check("div_c", C, 32'hFFFF_FFFD);
      check("div_lat", lat, 33);
      run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
      check("rem_c", C, 32'hFFFF_FFFF);
      run_op(OP_REMU, 32'd100, 32'd7, 1'b0, lat);
      check("remu_c", C, 32'd2);
      run_op(OP_DIVU, 32'd1234, 32'd0, 1'b0, lat);
      check("divu0_c", C, 32'hFFFF_FFFF);
      check("divu0_lat", lat, 1);
      run_op(OP_REM, 32'd1234, 32'd0, 1'b0, lat);
      check("rem0_c", C, 32'd1234);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
      check("divovf_c", C, 32'h8000_0000);
      check("divovf_lat", lat, 1);
      run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
      check("removf_c", C, 32'h0);

      // Back-pressure on a divide result, then back-to-back accept
      alu_op = OP_DIV; rD1 = 32'd100; rD2 = 32'hFFFF_FFF9; alub_sel = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check("bp_lat", lat, 33);
      check("bp_c", C, 32'hFFFF_FFF2);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_c", C, 32'hFFFF_FFF2);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_ready", in_ready, 0);
      end
      alu_op = OP_ADD; rD1 = 32'd10; rD2 = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("b2b_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("b2b_valid", out_valid, 1);
      check("b2b_c", C, 32'd30);

      // Flush during BUSY with a same-cycle request, then flush in IDLE
      alu_op = OP_DIV; rD1 = 32'd100; rD2 = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      alu_op = OP_ADD; rD1 = 32'd1; rD2 = 32'd1; flush = 1'b1; in_valid = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("flush_no_result", seen, 0);
      flush = 1'b1; in_valid = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_idle_no_accept", out_valid, 0);
      run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat);
      check("post_flush_divu_c", C, 32'd14);
      check("post_flush_divu_lat", lat, 33);
      tick();

      // 16-bit instance
      run16(OP_ADD, 16'h7FFF, 16'h0001, lat);
      check("x16_add_c", c16, 32'h8000);
      check("x16_add_lat", lat, 1);
      check("x16_add_bf", bf16, 0);
      run16(OP_DIV, 16'hFFF9, 16'd2, lat);
      check("x16_div_c", c16, 32'hFFFD);
      check("x16_div_lat", lat, 17);
      run16(OP_REM, 16'hFFF9, 16'd2, lat);
      check("x16_rem_c", c16, 32'hFFFF);
      run16(OP_MULHU, 16'hFFFF, 16'hFFFF, lat);
      check("x16_mulhu_c", c16, 32'hFFFE);
      check("x16_mulhu_lat", lat, 17);
      op16 = OP_DIV; a16 = 16'd100; b16 = 16'd7; iv16 = 1'b1;
      tick();
      iv16 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      op16 = OP_ADD; a16 = 16'd1; b16 = 16'd1; flush16 = 1'b1; iv16 = 1'b1;
      tick();
      flush16 = 1'b0; iv16 = 1'b0;
      check("x16_flush_out_valid", ov16, 0);
      check("x16_flush_in_ready", ir16, 1);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (ov16) seen++;
      end
      check("x16_flush_no_result", seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
